scariv_l2_resp_engine: RTL



---
 rtl/scariv_l2_resp_engine_pkg.sv | 12 +
 rtl/scariv_lsu_pkg.sv | 25 ++
 rtl/scariv_l2_if.sv | 20 ++
 rtl/scariv_l2_resp_fifo.sv | 45 ++++
 rtl/scariv_l2_resp_engine.sv | 135 +++++++++++++
 5 files changed

// File: rtl/scariv_l2_resp_engine_pkg.sv
// Constants for the L2 response engine's optional backpressure generator.
package scariv_l2_resp_engine_pkg;

  localparam logic [15:0] L2_RESP_LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] L2_RESP_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] l2_resp_lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & L2_RESP_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/scariv_lsu_pkg.sv
// LSU-side L2 protocol types shared by requesters and responders.
package scariv_lsu_pkg;

  localparam int L2_CMD_TAG_W = 4;
  localparam int L2_LINE_W    = 128;
  localparam int L2_ADDR_W    = 32;

  typedef logic [1:0] mem_cmd_t;
  localparam mem_cmd_t M_XRD = 2'd0;
  localparam mem_cmd_t M_XWR = 2'd1;

  typedef logic [L2_LINE_W-1:0] l2_line_t;

  typedef struct packed {
    mem_cmd_t                   cmd;
    logic [L2_ADDR_W-1:0]       addr;
    l2_line_t                   data;
    logic [L2_LINE_W/8-1:0]     byte_en;
  } l2_req_t;

  typedef struct packed {
    l2_line_t data;
  } l2_resp_t;

endpackage

// File: rtl/scariv_l2_if.sv
// L2 request and response handshake interfaces (valid/ready with opaque tag).
interface l2_req_if #(parameter int TAG_W = scariv_lsu_pkg::L2_CMD_TAG_W);
  logic                     valid;
  logic [TAG_W-1:0]         tag;
  scariv_lsu_pkg::l2_req_t  payload;
  logic                     ready;

  modport master (output valid, tag, payload, input ready);
  modport slave  (input valid, tag, payload, output ready);
endinterface

interface l2_resp_if #(parameter int TAG_W = scariv_lsu_pkg::L2_CMD_TAG_W);
  logic                     valid;
  logic [TAG_W-1:0]         tag;
  scariv_lsu_pkg::l2_resp_t payload;
  logic                     ready;

  modport master (output valid, tag, payload, input ready);
  modport slave  (input valid, tag, payload, output ready);
endinterface

// File: rtl/scariv_l2_resp_fifo.sv
// Generic synchronous FIFO with registered head output and async active-high reset.
module scariv_l2_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/scariv_l2_resp_engine.sv
// L2 responder: line-wide backing store, fixed-latency response pipeline, credit-protected FIFO.
// Optional macro SCARIV_L2_RESP_STALL_EN adds LFSR-driven request backpressure.
module scariv_l2_resp_engine
  import scariv_lsu_pkg::*;
  import scariv_l2_resp_engine_pkg::*;
#(
  parameter int TAG_W      = L2_CMD_TAG_W,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 4,
  parameter int RESP_DEPTH = 4
) (
  input logic       i_clk,
  input logic       i_reset,
  l2_req_if.slave   l2_req,
  l2_resp_if.master l2_resp
);

  localparam int LINE_W = $bits(l2_line_t);
  localparam int LINE_B = LINE_W / 8;
  localparam int OFF_W  = $clog2(LINE_B);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    l2_line_t         data;
  } entry_t;

  logic [CNT_W-1:0] cnt;
  logic             credit_ok;
  logic             stall;
  logic             accept;
  logic             pop;
  logic             is_wr;
  logic [IDX_W-1:0] idx;
  l2_line_t         acc_data;
  l2_line_t         store [MEM_WORDS];

  logic             pipe_vld   [LATENCY];
  entry_t           pipe_entry [LATENCY];

  entry_t           head;
  logic             fifo_empty;
  logic             fifo_full;

`ifdef SCARIV_L2_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) lfsr <= L2_RESP_LFSR_SEED;
    else         lfsr <= l2_resp_lfsr_next(lfsr);
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Ready depends on registered state only so the master may wait on it.
  assign credit_ok    = (cnt < CNT_W'(RESP_DEPTH));
  assign l2_req.ready = !i_reset && credit_ok && !stall;
  assign accept       = l2_req.valid && l2_req.ready;
  assign pop          = l2_resp.valid && l2_resp.ready;

  assign is_wr    = (l2_req.payload.cmd == M_XWR);
  assign idx      = l2_req.payload.addr[OFF_W +: IDX_W];
  assign acc_data = is_wr ? '0 : store[idx];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Backing store is deliberately left out of reset so data survives a reset pulse.
  always_ff @(posedge i_clk) begin
    if (accept && is_wr) begin
      for (int b = 0; b < LINE_B; b++) begin
        if (l2_req.payload.byte_en[b]) store[idx][b*8 +: 8] <= l2_req.payload.data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i]   <= 1'b0;
        pipe_entry[i] <= '0;
      end
    end else begin
      pipe_vld[0]   <= accept;
      pipe_entry[0] <= '{tag: l2_req.tag, data: acc_data};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]   <= pipe_vld[i-1];
        pipe_entry[i] <= pipe_entry[i-1];
      end
    end
  end

  scariv_l2_resp_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (pipe_vld[LATENCY-1]),
    .din     (pipe_entry[LATENCY-1]),
    .pop     (pop),
    .dout    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign l2_resp.valid   = !fifo_empty;
  assign l2_resp.tag     = head.tag;
  assign l2_resp.payload = '{data: head.data};

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(accept && (l2_req.payload.cmd != M_XRD) && (l2_req.payload.cmd != M_XWR)))
        else $error("l2_resp_engine: unknown cmd %0d accepted, handled as read", l2_req.payload.cmd);
      assert (!(pipe_vld[LATENCY-1] && fifo_full && !pop))
        else $error("l2_resp_engine: response FIFO overflow");
    end
  end
`endif

endmodule
